// File: rtl/remote_pkg.sv
// Shared definitions for the Knight's Tour host remote: response codes, default baud divisor,
// TX sequencing states and command encodings used by the benches.
package remote_pkg;

    localparam int          BAUD_DIV_DEFAULT = 2604;
    localparam int          FRAME_BITS       = 10;

    localparam logic [7:0]  RESP_ACK = 8'hA5;
    localparam logic [15:0] CAL_GYRO = 16'h2000;
    localparam logic [3:0]  OP_MOVE  = 4'h4;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } rc_state_t;

    // Move command: [15:12] opcode, [11:4] heading, [3:0] number of squares.
    function automatic logic [15:0] move_cmd(input logic [7:0] heading, input logic [3:0] squares);
        return {OP_MOVE, heading, squares};
    endfunction

endpackage

// File: rtl/uart.sv
// 8N1 UART used by the host remote: a transmitter whose frame-done strobe is combinational so the
// next frame can load on the same edge, and a mid-bit sampling receiver behind a 2-flop synchronizer.
module uart
    import remote_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rdy,
    input  logic       clr_rdy
);

    localparam int               CNT_W     = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

    logic [9:0]       tx_shft;
    logic [CNT_W-1:0] tx_baud;
    logic [3:0]       tx_bits;
    logic             tx_busy;
    logic             tx_bit_end;

    logic             rx_ff1;
    logic             rx_ff2;
    logic             rx_prev;
    logic             rx_busy;
    logic [CNT_W-1:0] rx_baud;
    logic [3:0]       rx_bits;
    logic [8:0]       rx_shft;
    logic             rx_start;
    logic             rx_sample;
    logic             rx_last;

    assign tx_bit_end = tx_busy && (tx_baud == BAUD_LAST);
    assign tx_done    = tx_bit_end && (tx_bits == LAST_BIT);
    assign TX         = tx_shft[0];

    // A load on trmt overrides the end of the current stop bit, giving gap-free back-to-back frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft <= '1;
            tx_baud <= '0;
            tx_bits <= '0;
            tx_busy <= 1'b0;
        end else if (trmt) begin
            tx_shft <= {1'b1, tx_data, 1'b0};
            tx_baud <= '0;
            tx_bits <= '0;
            tx_busy <= 1'b1;
        end else if (tx_busy) begin
            if (tx_bit_end) begin
                tx_shft <= {1'b1, tx_shft[9:1]};
                tx_baud <= '0;
                tx_bits <= tx_bits + 4'd1;
                if (tx_done) begin
                    tx_busy <= 1'b0;
                end
            end else begin
                tx_baud <= tx_baud + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1  <= 1'b1;
            rx_ff2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_ff1  <= RX;
            rx_ff2  <= rx_ff1;
            rx_prev <= rx_ff2;
        end
    end

    assign rx_start  = !rx_busy && rx_prev && !rx_ff2;
    assign rx_sample = rx_busy && (rx_baud == '0);
    assign rx_last   = rx_sample && (rx_bits == LAST_BIT);

    // The baud counter counts down to each sample point: half a bit first, then whole bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy <= 1'b0;
            rx_baud <= '0;
            rx_bits <= '0;
            rx_data <= 8'h00;
            rdy     <= 1'b0;
        end else begin
            if (rx_start) begin
                rx_busy <= 1'b1;
                rx_baud <= HALF_LAST;
                rx_bits <= '0;
            end else if (rx_sample) begin
                rx_baud <= BAUD_LAST;
                rx_bits <= rx_bits + 4'd1;
                if (rx_last) begin
                    rx_busy <= 1'b0;
                    rx_data <= rx_shft[8:1];
                end
            end else if (rx_busy) begin
                rx_baud <= rx_baud - CNT_W'(1);
            end

            if (rx_last) begin
                rdy <= 1'b1;
            end else if (rx_start || clr_rdy) begin
                rdy <= 1'b0;
            end
        end
    end

    // On the stop-bit sample the register holds start, d0..d7, so the byte sits in [8:1].
    always_ff @(posedge clk) begin
        if (rx_sample) begin
            rx_shft <= {rx_ff2, rx_shft[8:1]};
        end
    end

endmodule

// File: rtl/remote_comm.sv
// Host-side remote for the Knight's Tour benches: sends a 16-bit command as two UART frames,
// high byte first, and captures the robot's one-byte response.
module remote_comm
    import remote_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    rc_state_t  state;
    rc_state_t  state_nxt;
    logic [7:0] low_byte;
    logic [7:0] tx_data;
    logic       trmt;
    logic       tx_done;
    logic       accept;
    logic       sent_set;

    uart #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk    (clk),
        .rst_n  (rst_n),
        .RX     (RX),
        .TX     (TX),
        .tx_data(tx_data),
        .trmt   (trmt),
        .tx_done(tx_done),
        .rx_data(resp),
        .rdy    (resp_rdy),
        .clr_rdy(accept)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // send_cmd is only honoured in IDLE; requests during a transfer are dropped silently.
    always_comb begin
        state_nxt = state;
        trmt      = 1'b0;
        tx_data   = low_byte;
        accept    = 1'b0;
        sent_set  = 1'b0;
        case (state)
            IDLE: begin
                if (send_cmd) begin
                    accept    = 1'b1;
                    trmt      = 1'b1;
                    tx_data   = cmd[15:8];
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (tx_done) begin
                    trmt      = 1'b1;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (tx_done) begin
                    sent_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            low_byte <= cmd[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_sent <= 1'b0;
        end else if (accept) begin
            cmd_sent <= 1'b0;
        end else if (sent_set) begin
            cmd_sent <= 1'b1;
        end
    end

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: decodes TX frames against an expected byte queue, drives RX frames and
// checks responses, latency, ignored requests and mid-frame reset.
module tb_remote_comm;
    import remote_pkg::*;

    localparam int BD       = 16;
    localparam int FRAME    = 10 * BD;
    localparam int CMD_CLKS = 2 * FRAME;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        RX       = 1'b1;
    logic        send_cmd = 1'b0;
    logic [15:0] cmd      = 16'h0000;
    logic        TX;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int n_tests    = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int sent_rises = 0;

    logic [7:0] exp_q[$];
    bit         exp_second_q[$];
    int         done_edge   = 0;
    int         last_accept = 0;
    logic [7:0] exp_resp    = 8'h00;

    remote_comm #(
        .BAUD_DIV(BD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .TX      (TX),
        .cmd     (cmd),
        .send_cmd(send_cmd),
        .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy),
        .resp    (resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge cmd_sent) sent_rises <= sent_rises + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A request is accepted only if the previous command finished before the sampling edge.
    task automatic pulse(input logic [15:0] c);
        @(negedge clk);
        cmd      = c;
        send_cmd = 1'b1;
        if (cyc + 1 > done_edge) begin
            exp_q.push_back(c[15:8]);
            exp_second_q.push_back(1'b0);
            exp_q.push_back(c[7:0]);
            exp_second_q.push_back(1'b1);
            last_accept = cyc + 1;
            done_edge   = cyc + 1 + CMD_CLKS;
        end
        @(negedge clk);
        send_cmd = 1'b0;
    endtask

    task automatic wait_sent();
        int lat;
        while (!cmd_sent && (cyc - last_accept) < CMD_CLKS + 64) @(negedge clk);
        lat = cyc - last_accept;
        chk("cmd_sent_latency", lat,
            (lat >= CMD_CLKS - 2 && lat <= CMD_CLKS + 2) ? lat : CMD_CLKS);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            if (i == 0) begin
                repeat (BD / 2) @(negedge clk);
                chk("rx_rdy_clr_at_start", 32'(resp_rdy), 0);
                chk("rx_resp_hold", 32'(resp), 32'(exp_resp));
                repeat (BD - BD / 2) @(negedge clk);
            end else begin
                repeat (BD) @(negedge clk);
            end
        end
        exp_resp = b;
        chk("rx_resp", 32'(resp), 32'(exp_resp));
        chk("rx_rdy", 32'(resp_rdy), 1);
    endtask

    initial begin : tx_decoder
        logic [9:0] bits;
        logic [7:0] exp_b;
        bit         stable;
        bit         aborted;
        bit         second;
        int         n;
        int         t_start;
        int         t_prev;
        t_prev = 0;
        forever begin
            @(negedge clk);
            if (rst_n && TX === 1'b0) begin
                t_start = cyc;
                stable  = 1'b1;
                aborted = 1'b0;
                bits    = '1;
                n       = 0;
                while (n < FRAME && !aborted) begin
                    if (n > 0) @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    else if (n % BD == 0) bits[n / BD] = TX;
                    else if (TX !== bits[n / BD]) stable = 1'b0;
                    n++;
                end
                if (!aborted) begin
                    chk("tx_frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_b  = exp_q.pop_front();
                        second = exp_second_q.pop_front();
                        chk("tx_byte", 32'(bits[8:1]), 32'(exp_b));
                        chk("tx_stop_bit", 32'(bits[9]), 1);
                        chk("tx_bit_width", 32'(stable), 1);
                        if (second) chk("tx_back_to_back", t_start - t_prev, FRAME);
                    end
                    t_prev = t_start;
                end
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] c;
        logic [7:0]  b;
        int          d;
        int          r0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(TX), 1);
        chk("reset_cmd_sent", 32'(cmd_sent), 0);
        chk("reset_resp_rdy", 32'(resp_rdy), 0);
        chk("reset_resp", 32'(resp), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_tx", 32'(TX), 1);

        r0 = sent_rises;
        pulse(CAL_GYRO);
        wait_sent();
        chk("cal_sent_once", sent_rises - r0, 1);
        repeat (10) @(negedge clk);
        chk("cmd_sent_hold", 32'(cmd_sent), 1);

        r0 = sent_rises;
        pulse(move_cmd(8'h00, 4'h1));
        repeat (40) @(negedge clk);
        pulse(16'hFFFF);
        chk("busy_cmd_sent_low", 32'(cmd_sent), 0);
        wait_sent();
        chk("busy_sent_once", sent_rises - r0, 1);

        rx_byte(RESP_ACK);
        rx_byte(8'h5A);

        for (int it = 0; it < 6; it++) begin
            c  = (it % 2 == 1) ? 16'($urandom)
                               : move_cmd(8'($urandom_range(0, 255)), 4'($urandom_range(1, 15)));
            b  = 8'($urandom_range(0, 255));
            d  = $urandom_range(0, 120);
            r0 = sent_rises;
            fork
                begin
                    pulse(c);
                    repeat (30 + d) @(negedge clk);
                    pulse(16'($urandom));
                    wait_sent();
                end
                begin
                    repeat (d) @(negedge clk);
                    rx_byte(b);
                end
            join
            chk("rand_sent_once", sent_rises - r0, 1);
            chk("rand_rdy_kept", 32'(resp_rdy), 1);
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end

        pulse(move_cmd(8'h50, 4'h0));
        rx_byte(8'h66);
        @(negedge clk);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        repeat (BD) @(negedge clk);
        RX = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_pre_tx_low", 32'(TX), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        exp_second_q.delete();
        done_edge = 0;
        exp_resp  = 8'h00;
        #1;
        chk("abort_tx", 32'(TX), 1);
        chk("abort_cmd_sent", 32'(cmd_sent), 0);
        chk("abort_resp_rdy", 32'(resp_rdy), 0);
        chk("abort_resp", 32'(resp), 0);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        chk("abort_rx_discard_rdy", 32'(resp_rdy), 0);
        chk("abort_rx_discard_resp", 32'(resp), 0);
        chk("abort_tx_idle", 32'(TX), 1);

        r0 = sent_rises;
        pulse(move_cmd(8'hA3, 4'h7));
        wait_sent();
        chk("post_reset_sent_once", sent_rises - r0, 1);
        repeat (5) @(negedge clk);
        chk("tx_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
